// File: rtl/dcache_pkg.sv
// Shared types and helpers for the line-fill data cache.
package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    MISS_REQ,
    FILL,
    FLUSH_SCAN,
    FLUSH_WR,
    FLUSH_END
  } dc_state_t;

  localparam int unsigned LINE_WORDS = 16;
  localparam int unsigned HOST_W     = 512;

  // Line index of a word address for a window of 2^index_w lines.
  function automatic logic [31:0] line_of(input logic [31:0] addr, input int unsigned index_w);
    logic [31:0] mask;
    mask = (32'd1 << index_w) - 32'd1;
    return (addr >> 4) & mask;
  endfunction

endpackage

// File: rtl/dcache_data_ram.sv
// Data array: word write/read ports for the core side, full-line write for
// fills and full-line read for writeback. Contents are not reset.
module dcache_data_ram
  import dcache_pkg::*;
#(
  parameter int unsigned INDEX_W = 8
) (
  input  logic                clk,
  input  logic                word_we,
  input  logic [INDEX_W+3:0]  word_addr,
  input  logic [31:0]         word_wdata,
  input  logic                line_we,
  input  logic [INDEX_W-1:0]  line_widx,
  input  logic [HOST_W-1:0]   line_wdata,
  input  logic [INDEX_W+3:0]  rd_addr,
  output logic [31:0]         rd_word,
  input  logic [INDEX_W-1:0]  line_ridx,
  output logic [HOST_W-1:0]   line_rd
);

  localparam int unsigned DEPTH = 1 << (INDEX_W + 4);

  logic [31:0] mem [DEPTH];

  // Line fill and word write; the FSM never issues both in one cycle.
  always_ff @(posedge clk) begin
    if (line_we) begin
      for (int unsigned k = 0; k < LINE_WORDS; k++) begin
        mem[{line_widx, k[3:0]}] <= line_wdata[32*k +: 32];
      end
    end
    if (word_we) begin
      mem[word_addr] <= word_wdata;
    end
  end

  assign rd_word = mem[rd_addr];

  // Gather one full line for the writeback channel.
  always_comb begin
    line_rd = '0;
    for (int unsigned k = 0; k < LINE_WORDS; k++) begin
      line_rd[32*k +: 32] = mem[{line_ridx, k[3:0]}];
    end
  end

endmodule

// File: rtl/dcache_line_fill.sv
// Direct-mapped, word-addressed data cache with write-allocate, per-line
// dirty tracking and a flush engine writing dirty lines back to the host.
module dcache_line_fill
  import dcache_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0001_0000,
  parameter int unsigned INDEX_W    = 8,
  parameter int unsigned RSVD_LINES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       d_addr,
  input  logic              d_rd,
  input  logic              d_wr,
  input  logic [31:0]       d_wr_data,
  output logic              d_stall,
  output logic              d_rd_valid,
  output logic [31:0]       d_rd_data,
  output logic              d_segfault,
  output logic              host_rd_req,
  output logic [31:0]       host_rd_addr,
  input  logic              host_rd_valid,
  input  logic [31:0]       host_rd_resp_addr,
  input  logic [HOST_W-1:0] host_rd_data,
  output logic              host_wr_req,
  output logic [31:0]       host_wr_addr,
  output logic [HOST_W-1:0] host_wr_data,
  input  logic              host_wr_ack,
  input  logic              flush,
  output logic              flush_done
);

  localparam int unsigned NLINES = 1 << INDEX_W;
  localparam int unsigned WA_W   = INDEX_W + 4;
  localparam logic [INDEX_W-1:0] IDX_ONE = 1;

  dc_state_t state, nstate;

  logic [31:0]        req_addr;
  logic [31:0]        req_data;
  logic               req_wr;
  logic [INDEX_W-1:0] scan_idx;
  logic [NLINES-1:0]  valid;
  logic [NLINES-1:0]  dirty;

  logic [31:0]        d_line;
  logic [INDEX_W-1:0] d_idx;
  logic [INDEX_W-1:0] req_idx;
  logic               illegal;
  logic               resp_match;
  logic               unused_resp_bits;

  logic               word_we;
  logic [WA_W-1:0]    word_addr;
  logic [31:0]        word_wdata;
  logic               line_we;
  logic [WA_W-1:0]    rd_addr;
  logic [31:0]        rd_word;
  logic [HOST_W-1:0]  line_rd;

  logic               rd_fire;
  logic               seg_fire;
  logic               done_fire;
  logic               latch_req;
  logic               scan_step;
  logic               wb_done;

  assign d_line     = line_of(d_addr, INDEX_W);
  assign d_idx      = d_line[INDEX_W-1:0];
  assign req_idx    = req_addr[WA_W-1:4];
  assign illegal    = (d_addr[31:WA_W] != BASE_ADDR[31:WA_W]) || (d_line < RSVD_LINES);
  assign resp_match = host_rd_valid && (host_rd_resp_addr[31:4] == req_addr[31:4]);
  assign unused_resp_bits = ^host_rd_resp_addr[3:0];

  dcache_data_ram #(
    .INDEX_W(INDEX_W)
  ) u_ram (
    .clk       (clk),
    .word_we   (word_we),
    .word_addr (word_addr),
    .word_wdata(word_wdata),
    .line_we   (line_we),
    .line_widx (req_idx),
    .line_wdata(host_rd_data),
    .rd_addr   (rd_addr),
    .rd_word   (rd_word),
    .line_ridx (scan_idx),
    .line_rd   (line_rd)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nstate;
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    nstate     = state;
    word_we    = 1'b0;
    word_addr  = d_addr[WA_W-1:0];
    word_wdata = d_wr_data;
    line_we    = 1'b0;
    rd_addr    = d_addr[WA_W-1:0];
    rd_fire    = 1'b0;
    seg_fire   = 1'b0;
    done_fire  = 1'b0;
    latch_req  = 1'b0;
    scan_step  = 1'b0;
    wb_done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (flush) begin
          nstate = FLUSH_SCAN;
        end else if (d_rd || d_wr) begin
          if (illegal) begin
            seg_fire = 1'b1;
          end else if (!valid[d_idx]) begin
            latch_req = 1'b1;
            nstate    = MISS_REQ;
          end else if (d_wr) begin
            word_we = 1'b1;
          end else begin
            rd_fire = 1'b1;
          end
        end
      end
      MISS_REQ: begin
        if (resp_match) begin
          line_we = 1'b1;
          nstate  = FILL;
        end
      end
      FILL: begin
        word_addr  = req_addr[WA_W-1:0];
        word_wdata = req_data;
        rd_addr    = req_addr[WA_W-1:0];
        if (req_wr) word_we = 1'b1;
        else        rd_fire = 1'b1;
        nstate = IDLE;
      end
      FLUSH_SCAN: begin
        if (valid[scan_idx] && dirty[scan_idx]) begin
          nstate = FLUSH_WR;
        end else begin
          scan_step = 1'b1;
          if (scan_idx == '1) nstate = FLUSH_END;
        end
      end
      FLUSH_WR: begin
        if (host_wr_ack) begin
          wb_done   = 1'b1;
          scan_step = 1'b1;
          // The last line exits directly rather than wrapping the scan to 0.
          nstate    = (scan_idx == '1) ? FLUSH_END : FLUSH_SCAN;
        end
      end
      FLUSH_END: begin
        done_fire = 1'b1;
        nstate    = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  // Latch the missing request so it can complete after the fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr <= '0;
      req_data <= '0;
      req_wr   <= 1'b0;
    end else if (latch_req) begin
      req_addr <= d_addr;
      req_data <= d_wr_data;
      req_wr   <= d_wr;
    end
  end

  // Per-line valid/dirty tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (line_we) begin
        valid[req_idx] <= 1'b1;
        dirty[req_idx] <= 1'b0;
      end
      if (word_we) dirty[word_addr[WA_W-1:4]] <= 1'b1;
      if (wb_done) dirty[scan_idx] <= 1'b0;
    end
  end

  // Flush scan counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      scan_idx <= '0;
    else if (state == IDLE && flush) scan_idx <= '0;
    else if (scan_step)              scan_idx <= scan_idx + IDX_ONE;
  end

  // Registered core-side response pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_rd_valid <= 1'b0;
      d_rd_data  <= '0;
      d_segfault <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      d_rd_valid <= rd_fire;
      if (rd_fire) d_rd_data <= rd_word;
      d_segfault <= seg_fire;
      flush_done <= done_fire;
    end
  end

  assign d_stall      = (state != IDLE);
  assign host_rd_req  = (state == MISS_REQ);
  assign host_rd_addr = host_rd_req ? {req_addr[31:4], 4'h0} : '0;
  assign host_wr_req  = (state == FLUSH_WR);
  assign host_wr_addr = host_wr_req ? {BASE_ADDR[31:WA_W], scan_idx, 4'h0} : '0;
  assign host_wr_data = host_wr_req ? line_rd : '0;

endmodule

// File: tb/tb_dcache_line_fill.sv
// Scoreboard bench for dcache_line_fill: stimulus pushes expected events,
// a negedge monitor pops and compares whenever the DUT presents one.
module tb_dcache_line_fill;

  localparam int NL = 256;
  localparam int K_RD = 0, K_SEG = 1, K_HRD = 2, K_HWR = 3, K_DONE = 4;

  typedef struct {
    int          kind;
    logic [31:0] addr;
    logic [31:0] data;
    int          woff;
  } ev_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [31:0]  d_addr = '0;
  logic         d_rd = 1'b0;
  logic         d_wr = 1'b0;
  logic [31:0]  d_wr_data = '0;
  logic         d_stall;
  logic         d_rd_valid;
  logic [31:0]  d_rd_data;
  logic         d_segfault;
  logic         host_rd_req;
  logic [31:0]  host_rd_addr;
  logic         host_rd_valid = 1'b0;
  logic [31:0]  host_rd_resp_addr = '0;
  logic [511:0] host_rd_data = '0;
  logic         host_wr_req;
  logic [31:0]  host_wr_addr;
  logic [511:0] host_wr_data;
  logic         host_wr_ack = 1'b0;
  logic         flush = 1'b0;
  logic         flush_done;

  int  n_cmp = 0;
  int  n_err = 0;
  ev_t sb[$];
  logic prev_hrd = 1'b0;
  logic prev_hwr = 1'b0;

  dcache_line_fill #(
    .BASE_ADDR (32'h0001_0000),
    .INDEX_W   (8),
    .RSVD_LINES(32)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .d_addr           (d_addr),
    .d_rd             (d_rd),
    .d_wr             (d_wr),
    .d_wr_data        (d_wr_data),
    .d_stall          (d_stall),
    .d_rd_valid       (d_rd_valid),
    .d_rd_data        (d_rd_data),
    .d_segfault       (d_segfault),
    .host_rd_req      (host_rd_req),
    .host_rd_addr     (host_rd_addr),
    .host_rd_valid    (host_rd_valid),
    .host_rd_resp_addr(host_rd_resp_addr),
    .host_rd_data     (host_rd_data),
    .host_wr_req      (host_wr_req),
    .host_wr_addr     (host_wr_addr),
    .host_wr_data     (host_wr_data),
    .host_wr_ack      (host_wr_ack),
    .flush            (flush),
    .flush_done       (flush_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [31:0] addr, input logic [31:0] data, input int woff);
    ev_t e;
    e.kind = kind; e.addr = addr; e.data = data; e.woff = woff;
    sb.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [31:0] addr, input logic [31:0] data,
                         input logic [511:0] line);
    ev_t e;
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_event: got kind %0d expected no event", kind);
    end else begin
      e = sb.pop_front();
      check("event_kind", kind, e.kind);
      if (kind == e.kind) begin
        case (kind)
          K_RD:    check("rd_data", data, e.data);
          K_HRD:   check("host_rd_addr", addr, e.addr);
          K_HWR: begin
            check("host_wr_addr", addr, e.addr);
            check("host_wr_word", line[e.woff*32 +: 32], e.data);
          end
          default: ;
        endcase
      end
    end
  endtask

  // Monitor: every presented output event is matched against the scoreboard.
  always @(negedge clk) begin
    if (d_rd_valid) observe(K_RD, 32'h0, d_rd_data, '0);
    if (d_segfault) observe(K_SEG, 32'h0, 32'h0, '0);
    if (host_rd_req && !prev_hrd) observe(K_HRD, host_rd_addr, 32'h0, '0);
    if (host_wr_req && !prev_hwr) observe(K_HWR, host_wr_addr, 32'h0, host_wr_data);
    if (flush_done) observe(K_DONE, 32'h0, 32'h0, '0);
    prev_hrd = host_rd_req;
    prev_hwr = host_wr_req;
  end

  function automatic logic [511:0] mkline(input logic [31:0] b);
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[32*k +: 32] = b + 32'(k);
    return l;
  endfunction

  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] dat);
    @(negedge clk);
    d_rd = rd; d_wr = wr; d_addr = a; d_wr_data = dat;
    @(negedge clk);
    d_rd = 1'b0; d_wr = 1'b0;
  endtask

  task automatic reply(input logic [31:0] a, input logic [511:0] line);
    @(negedge clk);
    host_rd_valid = 1'b1; host_rd_resp_addr = a; host_rd_data = line;
    @(negedge clk);
    host_rd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (d_stall && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, d_stall, 1'b0);
  endtask

  // Flush with a fixed ack latency; checks total cycles from the sampling edge.
  task automatic do_flush(input int ndirty, input int lat);
    int cyc, wcnt;
    bit seen;
    @(negedge clk);
    flush = 1'b1;
    cyc = 0; wcnt = 0; seen = 1'b0;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      flush = 1'b0;
      host_wr_ack = 1'b0;
      if (flush_done) seen = 1'b1;
      else if (host_wr_req) begin
        if (wcnt == lat) begin
          host_wr_ack = 1'b1;
          wcnt = 0;
        end else wcnt++;
      end
    end
    host_wr_ack = 1'b0;
    check("flush_cycles", cyc, NL + 2 + ndirty * (1 + lat));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1);
  end

  initial begin
    int cnt;
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_stall", d_stall, 1'b0);
    check("rst_rd_valid", d_rd_valid, 1'b0);
    check("rst_segfault", d_segfault, 1'b0);
    check("rst_host_rd_req", host_rd_req, 1'b0);
    check("rst_host_wr_req", host_wr_req, 1'b0);
    check("rst_flush_done", flush_done, 1'b0);
    check("rst_rd_data", d_rd_data, 32'h0);
    rst_n = 1'b1;

    // Cold read miss
    push(K_HRD, 32'h0001_0200, 0, 0);
    push(K_RD, 0, 32'hDEAD_BEEF, 0);
    access(1, 0, 32'h0001_0200, 0);
    check("miss_stall_rise", d_stall, 1'b1);
    check("miss_host_req", host_rd_req, 1'b1);
    reply(32'h0001_0200, mkline(32'hDEAD_BEEF));
    check("fill_stall", d_stall, 1'b1);
    check("fill_no_early_valid", d_rd_valid, 1'b0);
    @(negedge clk);
    check("fill_rd_valid", d_rd_valid, 1'b1);
    check("fill_stall_fall", d_stall, 1'b0);

    // Segfaults: reserved line and out-of-window
    push(K_SEG, 0, 0, 0);
    access(1, 0, 32'h0001_0000, 0);
    check("seg_reserved", d_segfault, 1'b1);
    push(K_SEG, 0, 0, 0);
    access(1, 0, 32'h0002_0400, 0);
    check("seg_window", d_segfault, 1'b1);
    check("seg_no_host", host_rd_req, 1'b0);
    check("seg_no_stall", d_stall, 1'b0);

    // Fill line 0x300, write hit, read hit, rd+wr treated as write
    push(K_HRD, 32'h0001_0300, 0, 0);
    push(K_RD, 0, 32'h3000_0005, 0);
    access(1, 0, 32'h0001_0305, 0);
    reply(32'h0001_0300, mkline(32'h3000_0000));
    wait_idle("fill300_idle");
    access(0, 1, 32'h0001_0305, 32'h1234_5678);
    push(K_RD, 0, 32'h1234_5678, 0);
    access(1, 0, 32'h0001_0305, 0);
    check("hit_latency", d_rd_valid, 1'b1);
    access(1, 1, 32'h0001_0301, 32'hA5A5_A5A5);
    push(K_RD, 0, 32'hA5A5_A5A5, 0);
    access(1, 0, 32'h0001_0301, 0);
    push(K_HWR, 32'h0001_0300, 32'h1234_5678, 5);
    push(K_DONE, 0, 0, 0);
    do_flush(1, 2);

    // Write miss with allocate, then flush the merged line
    push(K_HRD, 32'h0001_0410, 0, 0);
    access(0, 1, 32'h0001_0410, 32'hCAFE_F00D);
    reply(32'h0001_0410, mkline(32'h4100_0000));
    wait_idle("wmiss_idle");
    push(K_RD, 0, 32'h4100_0001, 0);
    access(1, 0, 32'h0001_0411, 0);
    push(K_HWR, 32'h0001_0410, 32'hCAFE_F00D, 0);
    push(K_DONE, 0, 0, 0);
    do_flush(1, 0);
    push(K_DONE, 0, 0, 0);
    do_flush(0, 0);

    // Mismatched response ignored during MISS_REQ
    push(K_HRD, 32'h0001_0600, 0, 0);
    push(K_RD, 0, 32'h6000_0003, 0);
    access(1, 0, 32'h0001_0603, 0);
    reply(32'h0001_0500, mkline(32'h5500_0000));
    check("mismatch_stall", d_stall, 1'b1);
    @(negedge clk);
    check("mismatch_stall_hold", d_stall, 1'b1);
    check("mismatch_req_hold", host_rd_req, 1'b1);
    reply(32'h0001_0600, mkline(32'h6000_0000));
    wait_idle("match_idle");

    // Reset mid-flush aborts; stale response ignored; valid cleared
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    repeat (10) @(negedge clk);
    check("flush_busy", d_stall, 1'b1);
    rst_n = 1'b0;
    #1;
    check("reset_abort", d_stall, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    reply(32'h0001_0200, mkline(32'h9900_0000));
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (flush_done) cnt++;
    end
    check("no_flush_done_after_reset", cnt, 0);
    push(K_HRD, 32'h0001_0200, 0, 0);
    push(K_RD, 0, 32'h2200_0000, 0);
    access(1, 0, 32'h0001_0200, 0);
    reply(32'h0001_0200, mkline(32'h2200_0000));
    wait_idle("post_reset_idle");

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
